// File: rtl/lzw_pkg.sv
// rtl/lzw_pkg.sv - shared constants, dictionary field layout and FSM state type for the LZW decoder
package lzw_pkg;

    localparam int DICT_AW    = 14;
    localparam int DICT_DW    = 23;
    localparam int VALID_BIT  = 22;
    localparam int PREFIX_MSB = 21;
    localparam int PREFIX_LSB = 8;
    localparam int BYTE_MSB   = 7;
    localparam int BYTE_LSB   = 0;
    localparam int LIT_LIMIT  = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CAPTURE,
        ST_DRAIN
    } lzw_state_t;

    function automatic logic is_literal(input logic [31:0] code);
        return code < 32'(LIT_LIMIT);
    endfunction

endpackage

// File: rtl/lzw_byte_lifo.sv
// rtl/lzw_byte_lifo.sv - byte stack with dual push (b lands on top of a), single pop and flush
module lzw_byte_lifo #(
    parameter int DEPTH = 32,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push_a,
    input  logic [7:0]    data_a,
    input  logic          push_b,
    input  logic [7:0]    data_b,
    input  logic          pop,
    output logic [7:0]    top_data,
    output logic [CW-1:0] depth,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] idx_a;
    logic [AW-1:0] idx_b;
    logic [AW-1:0] idx_top;

    // The caller guarantees pushes never exceed DEPTH, so indices are never out of range when written.
    assign idx_a   = AW'(depth);
    assign idx_b   = AW'(depth + CW'(push_a));
    assign idx_top = AW'(depth - CW'(1));

    assign top_data = mem[idx_top];
    assign empty    = (depth == '0);

    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_a) begin
                mem[idx_a] <= data_a;
            end
            if (push_b) begin
                mem[idx_b] <= data_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
        end else if (flush) begin
            depth <= '0;
        end else begin
            depth <= depth + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

endmodule

// File: rtl/lzw_decode_seq.sv
// rtl/lzw_decode_seq.sv - walks LZW dictionary chains for each code and emits the recovered bytes in order
module lzw_decode_seq #(
    parameter int STACK_DEPTH = 32,
    parameter int DICT_AW     = lzw_pkg::DICT_AW
) (
    input  logic                       I_sys_clk,
    input  logic                       I_sys_rst_n,
    input  logic                       I_state_clr,
    input  logic [DICT_AW-1:0]         I_code,
    input  logic                       I_code_valid,
    output logic                       O_code_ready,
    output logic                       O_dict_rd_en,
    output logic [DICT_AW-1:0]         O_dict_rd_addr,
    input  logic [lzw_pkg::DICT_DW-1:0] I_dict_rd_data,
    output logic [7:0]                 O_payload_data,
    output logic                       O_payload_data_en,
    input  logic                       I_payload_ready,
    output logic                       O_busy,
    output logic                       O_err_invalid,
    output logic                       O_err_overflow,
    output logic [31:0]                O_byte_cnt
);

    import lzw_pkg::*;

    localparam int CW = $clog2(STACK_DEPTH + 1);

    lzw_state_t         state_q;
    lzw_state_t         state_d;
    logic [DICT_AW-1:0] addr_q;
    logic [DICT_AW-1:0] addr_d;
    logic               rdy_arm_q;
    logic               err_inv_q;
    logic               err_ovf_q;
    logic [31:0]        cnt_q;

    logic               push_a;
    logic               push_b;
    logic [7:0]         data_a;
    logic [7:0]         data_b;
    logic               pop;
    logic               flush;
    logic               set_inv;
    logic               set_ovf;
    logic [7:0]         top_data;
    logic [CW-1:0]      depth;
    logic               empty;

    logic               rd_valid;
    logic [PREFIX_MSB-PREFIX_LSB:0] rd_prefix;
    logic [7:0]         rd_byte;
    logic               prefix_lit;
    logic [CW:0]        fill;
    logic               accept;
    logic               fire;

    assign rd_valid   = I_dict_rd_data[VALID_BIT];
    assign rd_prefix  = I_dict_rd_data[PREFIX_MSB:PREFIX_LSB];
    assign rd_byte    = I_dict_rd_data[BYTE_MSB:BYTE_LSB];
    assign prefix_lit = is_literal(32'(rd_prefix));
    // Depth the stack would reach if this capture's pushes were taken.
    assign fill       = {1'b0, depth} + (prefix_lit ? (CW+1)'(2) : (CW+1)'(1));

    // Ready stays low until the first clock after reset release.
    assign O_code_ready      = (state_q == ST_IDLE) && rdy_arm_q;
    assign accept            = I_code_valid && O_code_ready;
    assign O_payload_data_en = (state_q == ST_DRAIN) && !empty;
    assign O_payload_data    = O_payload_data_en ? top_data : 8'h00;
    assign fire              = O_payload_data_en && I_payload_ready;
    assign O_dict_rd_en      = (state_q == ST_LOOKUP);
    assign O_dict_rd_addr    = addr_q;
    assign O_busy            = (state_q != ST_IDLE);
    assign O_err_invalid     = err_inv_q;
    assign O_err_overflow    = err_ovf_q;
    assign O_byte_cnt        = cnt_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        push_a  = 1'b0;
        push_b  = 1'b0;
        data_a  = 8'h00;
        data_b  = 8'h00;
        pop     = 1'b0;
        flush   = 1'b0;
        set_inv = 1'b0;
        set_ovf = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_literal(32'(I_code))) begin
                        push_a  = 1'b1;
                        data_a  = I_code[7:0];
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d  = I_code;
                        state_d = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!rd_valid) begin
                    set_inv = 1'b1;
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else if (fill > (CW+1)'(STACK_DEPTH)) begin
                    set_ovf = 1'b1;
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // Suffix goes down first so the prefix byte ends up on top and pops first.
                    push_a = 1'b1;
                    data_a = rd_byte;
                    if (prefix_lit) begin
                        push_b  = 1'b1;
                        data_b  = rd_prefix[7:0];
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d  = DICT_AW'(rd_prefix);
                        state_d = ST_LOOKUP;
                    end
                end
            end
            ST_DRAIN: begin
                if (fire) begin
                    pop = 1'b1;
                    if (depth == CW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end else if (empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rdy_arm_q <= 1'b0;
            err_inv_q <= 1'b0;
            err_ovf_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rdy_arm_q <= 1'b1;
            err_inv_q <= set_inv | (err_inv_q & ~I_state_clr);
            err_ovf_q <= set_ovf | (err_ovf_q & ~I_state_clr);
            cnt_q     <= I_state_clr ? 32'(fire) : cnt_q + 32'(fire);
        end
    end

    lzw_byte_lifo #(
        .DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk      (I_sys_clk),
        .rst_n    (I_sys_rst_n),
        .flush    (flush),
        .push_a   (push_a),
        .data_a   (data_a),
        .push_b   (push_b),
        .data_b   (data_b),
        .pop      (pop),
        .top_data (top_data),
        .depth    (depth),
        .empty    (empty)
    );

endmodule
